// File: rtl/ps2_pad_poller.sv
// ps2_pad_poller: polls a PS2-style game pad over its SPI-like link and
// publishes button and analog axis state from every validated frame.
module ps2_pad_poller #(
   parameter int CLK_DIV     = 120,
   parameter int POLL_PERIOD = 816000,
   parameter int NBYTES      = 9,
   parameter int GAP_HALF    = 3
) (
   input  logic        CLK_40M,
   input  logic        rst,
   input  logic        start,
   input  logic        auto_en,
   input  logic        di,
   output logic        sdo,
   output logic        sclk,
   output logic        scs,
   output logic [15:0] buttons,
   output logic [7:0]  rx,
   output logic [7:0]  ry,
   output logic [7:0]  lx,
   output logic [7:0]  ly,
   output logic        analog,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        busy
);

   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam int PW = (GAP_HALF > 16) ? $clog2(GAP_HALF + 1) : 5;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, FINISH} state_t;

   state_t          state, state_nx;
   logic [TW-1:0]   tick_cnt;
   logic [CW-1:0]   poll_cnt;
   logic [PW-1:0]   ph;
   logic [4:0]      bidx;
   logic [7:0]      shreg;
   logic [7:0]      rxb [0:8];
   logic [7:0]      cmd;
   logic            cmd_bit;
   logic            tick, poll_hit, go, phase_done;
   logic            shift_end, last_byte, finish_end, frame_ok;

   assign tick       = (state != IDLE) && (tick_cnt == TW'(CLK_DIV - 1));
   assign poll_hit   = auto_en && (poll_cnt == CW'(POLL_PERIOD - 1));
   assign go         = (state == IDLE) && (start || poll_hit);
   assign shift_end  = tick && (state == SHIFT) && (ph == PW'(15));
   assign last_byte  = (bidx == 5'(NBYTES - 1));
   assign finish_end = tick && (state == FINISH);
   assign frame_ok   = ((rxb[1] == 8'h41) || (rxb[1] == 8'h73)) && (rxb[2] == 8'h5A);

   // Command byte for the current byte index, LSB shifted out first
   always_comb begin
      cmd = 8'h00;
      if (bidx == 5'd0)
         cmd = 8'h01;
      else if (bidx == 5'd1)
         cmd = 8'h42;
   end

   assign cmd_bit = cmd[ph[3:1]];

   // Next-state decode and line levels; ph[0] low is the sclk-low half of a bit
   always_comb begin
      state_nx   = state;
      phase_done = 1'b0;
      scs        = 1'b1;
      sclk       = 1'b1;
      sdo        = 1'b1;
      busy       = (state != IDLE);
      case (state)
         IDLE: if (go) state_nx = SETUP;
         SETUP: begin
            scs = 1'b0;
            if (tick && (ph == PW'(1))) begin
               phase_done = 1'b1;
               state_nx   = SHIFT;
            end
         end
         SHIFT: begin
            scs  = 1'b0;
            sclk = ph[0];
            sdo  = cmd_bit;
            if (shift_end) begin
               phase_done = 1'b1;
               if (last_byte)
                  state_nx = FINISH;
               else if (GAP_HALF == 0)
                  state_nx = SHIFT;
               else
                  state_nx = GAP;
            end
         end
         GAP: begin
            scs = 1'b0;
            if (tick && (ph == PW'(GAP_HALF - 1))) begin
               phase_done = 1'b1;
               state_nx   = SHIFT;
            end
         end
         FINISH: if (tick) begin
            phase_done = 1'b1;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLK_40M or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Half-period divider, held at zero while idle
   always_ff @(posedge CLK_40M or negedge rst) begin
      if (!rst)                         tick_cnt <= '0;
      else if ((state == IDLE) || tick) tick_cnt <= '0;
      else                              tick_cnt <= tick_cnt + 1'b1;
   end

   // Poll interval counter; an ignored expiry while busy simply wraps
   always_ff @(posedge CLK_40M or negedge rst) begin
      if (!rst)                  poll_cnt <= '0;
      else if (!auto_en || go)   poll_cnt <= '0;
      else if (poll_hit)         poll_cnt <= '0;
      else                       poll_cnt <= poll_cnt + 1'b1;
   end

   // Tick count within the current state phase
   always_ff @(posedge CLK_40M or negedge rst) begin
      if (!rst)                    ph <= '0;
      else if (go || phase_done)   ph <= '0;
      else if (tick)               ph <= ph + 1'b1;
   end

   // Byte index within the frame
   always_ff @(posedge CLK_40M or negedge rst) begin
      if (!rst)           bidx <= '0;
      else if (go)        bidx <= '0;
      else if (shift_end) bidx <= bidx + 1'b1;
   end

   // Receive shift register (sampled as sclk rises) and per-index byte store
   always_ff @(posedge CLK_40M or negedge rst) begin
      if (!rst) begin
         shreg <= '0;
         for (int unsigned i = 0; i < 9; i++) rxb[i] <= '0;
      end else begin
         if (tick && (state == SHIFT) && !ph[0])
            shreg <= {di, shreg[7:1]};
         if (shift_end && (bidx >= 5'd1) && (bidx <= 5'd8))
            rxb[bidx[3:0]] <= shreg;
      end
   end

   // Frame validation and output update at the end of FINISH
   always_ff @(posedge CLK_40M or negedge rst) begin
      if (!rst) begin
         buttons     <= '0;
         rx          <= 8'h80;
         ry          <= 8'h80;
         lx          <= 8'h80;
         ly          <= 8'h80;
         analog      <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         if (finish_end) begin
            if (frame_ok) begin
               frame_valid <= 1'b1;
               buttons     <= ~{rxb[4], rxb[3]};
               analog      <= (rxb[1] == 8'h73);
               if (rxb[1] == 8'h41) begin
                  rx <= 8'h80;
                  ry <= 8'h80;
                  lx <= 8'h80;
                  ly <= 8'h80;
               end else if (NBYTES >= 9) begin
                  rx <= rxb[5];
                  ry <= rxb[6];
                  lx <= rxb[7];
                  ly <= rxb[8];
               end
            end else begin
               frame_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_pad_poller.sv
// tb_ps2_pad_poller: randomized frames from a behavioural pad model, checked
// against a frame-level reference of the expected outputs and line timing.
module tb_ps2_pad_poller;

   localparam int CD  = 4;
   localparam int PP  = 1000;
   localparam int NB  = 9;
   localparam int GH  = 3;
   localparam int T_TICKS = 2 + NB * 16 + (NB - 1) * GH + 1;

   logic        CLK_40M, rst, start, auto_en, di;
   logic        sdo, sclk, scs, analog, frame_valid, frame_err, busy;
   logic [15:0] buttons;
   logic [7:0]  rx, ry, lx, ly;

   int          nvec, nmis;
   logic [7:0]  resp [0:NB-1];
   logic [7:0]  cur;
   int          pad_bit;
   int          low_pulses;
   bit          mosi [$];
   bit          exp_mosi [$];

   logic [15:0] exp_buttons;
   logic [7:0]  exp_rx, exp_ry, exp_lx, exp_ly;
   logic        exp_analog;

   ps2_pad_poller #(.CLK_DIV(CD), .POLL_PERIOD(PP), .NBYTES(NB), .GAP_HALF(GH)) dut (
      .CLK_40M(CLK_40M), .rst(rst), .start(start), .auto_en(auto_en), .di(di),
      .sdo(sdo), .sclk(sclk), .scs(scs), .buttons(buttons),
      .rx(rx), .ry(ry), .lx(lx), .ly(ly), .analog(analog),
      .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
   );

   initial begin
      CLK_40M = 1'b0;
      forever #5 CLK_40M = ~CLK_40M;
   end

   // Pad: presents the next response bit after each sclk falling edge
   initial begin
      di = 1'b1;
      pad_bit = 0;
      forever begin
         @(negedge sclk or posedge scs or negedge scs);
         if (scs === 1'b1) begin
            di = 1'b1;
            pad_bit = 0;
         end else if (sclk === 1'b0) begin
            if (pad_bit < NB * 8) begin
               cur = resp[pad_bit / 8];
               di = cur[pad_bit % 8];
            end
            pad_bit++;
         end else begin
            pad_bit = 0;
         end
      end
   end

   // Capture command bits as sclk rises while selected
   initial forever begin
      @(posedge sclk);
      if (scs === 1'b0) mosi.push_back(sdo);
   end

   initial forever begin
      @(negedge sclk);
      low_pulses++;
   end

   // Reference: what a frame with the current response does to the outputs
   task automatic model_frame(output bit v);
      v = ((resp[1] == 8'h41) || (resp[1] == 8'h73)) && (resp[2] == 8'h5A);
      if (v) begin
         exp_buttons = ~{resp[4], resp[3]};
         exp_analog  = (resp[1] == 8'h73);
         if (resp[1] == 8'h41)
            {exp_rx, exp_ry, exp_lx, exp_ly} = {4{8'h80}};
         else if (NB >= 9)
            {exp_rx, exp_ry, exp_lx, exp_ly} = {resp[5], resp[6], resp[7], resp[8]};
      end
   endtask

   task automatic model_reset();
      exp_buttons = '0;
      exp_analog  = 1'b0;
      {exp_rx, exp_ry, exp_lx, exp_ly} = {4{8'h80}};
   endtask

   task automatic random_resp(input bit force_valid);
      for (int i = 0; i < NB; i++) resp[i] = 8'($urandom);
      if (force_valid) begin
         resp[1] = ($urandom_range(0, 1) == 0) ? 8'h41 : 8'h73;
         resp[2] = 8'h5A;
      end
   endtask

   // Runs one frame (optionally kicked by start) and reports what was observed
   task automatic do_frame(input bit pulse, output int bcyc, output int scs_lo,
                           output bit gv, output bit ge, output bit tmo);
      bcyc = 0; scs_lo = 0; gv = 0; ge = 0; tmo = 1;
      mosi.delete();
      low_pulses = 0;
      if (pulse) begin
         start = 1'b1;
         @(negedge CLK_40M);
         start = 1'b0;
      end
      for (int i = 0; i < 5000; i++) begin
         if (busy) begin
            bcyc++;
            if (!scs) scs_lo++;
         end else if (bcyc > 0) begin
            gv = frame_valid;
            ge = frame_err;
            tmo = 0;
            break;
         end
         @(negedge CLK_40M);
      end
   endtask

   task automatic test_reset();
      @(negedge CLK_40M);
      nvec++;
      if ({scs, sclk, sdo, busy, frame_valid, frame_err, analog} !== 7'b1110000) begin
         nmis++;
         $display("FAIL reset_lines: got %b expected 1110000",
                  {scs, sclk, sdo, busy, frame_valid, frame_err, analog});
      end
      nvec++;
      if (buttons !== 16'h0000) begin
         nmis++;
         $display("FAIL reset_buttons: got %h expected 0000", buttons);
      end
      nvec++;
      if ({rx, ry, lx, ly} !== {4{8'h80}}) begin
         nmis++;
         $display("FAIL reset_axes: got %h expected 80808080", {rx, ry, lx, ly});
      end
   endtask

   task automatic test_idle_hold();
      int rises = 0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge CLK_40M);
         if (busy) rises++;
      end
      nvec++;
      if (rises != 0) begin
         nmis++;
         $display("FAIL idle_no_frame: got %0d busy cycles expected 0", rises);
      end
   endtask

   task automatic test_analog_frame();
      int bcyc, slo;
      bit gv, ge, tmo, v, bad;
      resp = '{8'hFF, 8'h73, 8'h5A, 8'hFE, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40};
      model_frame(v);
      do_frame(1'b1, bcyc, slo, gv, ge, tmo);
      nvec++;
      if ({tmo, gv, ge} !== 3'b010) begin
         nmis++;
         $display("FAIL analog_pulse: got tmo/v/e %b expected 010", {tmo, gv, ge});
      end
      nvec++;
      if ({buttons, rx, ry, lx, ly, analog} !== {16'h0001, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1}) begin
         nmis++;
         $display("FAIL analog_outputs: got %h %h %h %h %h %b expected 0001 10 20 30 40 1",
                  buttons, rx, ry, lx, ly, analog);
      end
      nvec++;
      if (bcyc != T_TICKS * CD) begin
         nmis++;
         $display("FAIL frame_length: got %0d expected %0d", bcyc, T_TICKS * CD);
      end
      nvec++;
      if (slo != (T_TICKS - 1) * CD) begin
         nmis++;
         $display("FAIL scs_low: got %0d expected %0d", slo, (T_TICKS - 1) * CD);
      end
      nvec++;
      if (low_pulses != NB * 8) begin
         nmis++;
         $display("FAIL sclk_pulses: got %0d expected %0d", low_pulses, NB * 8);
      end
      bad = (mosi.size() != exp_mosi.size());
      for (int i = 0; i < mosi.size() && !bad; i++) if (mosi[i] != exp_mosi[i]) bad = 1;
      nvec++;
      if (bad) begin
         nmis++;
         $display("FAIL sdo_stream: got %0d bits expected %0d bits of 01,42,00..",
                  mosi.size(), exp_mosi.size());
      end
      @(negedge CLK_40M);
      nvec++;
      if (frame_valid !== 1'b0) begin
         nmis++;
         $display("FAIL valid_width: got %b expected 0 one cycle later", frame_valid);
      end
   endtask

   task automatic test_digital_frame();
      int bcyc, slo;
      bit gv, ge, tmo, v;
      random_resp(1'b0);
      resp[1] = 8'h41; resp[2] = 8'h5A; resp[3] = 8'hDF; resp[4] = 8'h7F;
      model_frame(v);
      do_frame(1'b1, bcyc, slo, gv, ge, tmo);
      nvec++;
      if ({tmo, gv, ge, buttons, rx, ry, lx, ly, analog} !==
          {3'b010, 16'h8020, {4{8'h80}}, 1'b0}) begin
         nmis++;
         $display("FAIL digital_frame: got %b %h %h %h %h %h %b expected 010 8020 80 80 80 80 0",
                  {tmo, gv, ge}, buttons, rx, ry, lx, ly, analog);
      end
   endtask

   task automatic test_bad_frame();
      int bcyc, slo;
      bit gv, ge, tmo, v;
      random_resp(1'b0);
      resp[1] = 8'h73; resp[2] = 8'h00;
      model_frame(v);
      do_frame(1'b1, bcyc, slo, gv, ge, tmo);
      nvec++;
      if ({tmo, gv, ge, buttons, rx, ry, lx, ly, analog} !==
          {3'b001, 16'h8020, {4{8'h80}}, 1'b0}) begin
         nmis++;
         $display("FAIL bad_frame_hold: got %b %h %h %h %h %h %b expected 001 8020 80 80 80 80 0",
                  {tmo, gv, ge}, buttons, rx, ry, lx, ly, analog);
      end
      @(negedge CLK_40M);
      nvec++;
      if (frame_err !== 1'b0) begin
         nmis++;
         $display("FAIL err_width: got %b expected 0 one cycle later", frame_err);
      end
   endtask

   task automatic test_random();
      int bcyc, slo;
      bit gv, ge, tmo, v;
      for (int n = 0; n < 12; n++) begin
         random_resp(1'b0);
         case ($urandom_range(0, 3))
            0: resp[1] = 8'h41;
            1, 2: resp[1] = 8'h73;
            default: ;
         endcase
         if ($urandom_range(0, 4) != 0) resp[2] = 8'h5A;
         model_frame(v);
         do_frame(1'b1, bcyc, slo, gv, ge, tmo);
         nvec++;
         if ({tmo, gv, ge, buttons, rx, ry, lx, ly, analog, bcyc} !==
             {1'b0, v, !v, exp_buttons, exp_rx, exp_ry, exp_lx, exp_ly, exp_analog, T_TICKS * CD}) begin
            nmis++;
            $display("FAIL random_frame_%0d: got %b%b%b %h %h %h %h %h %b %0d expected 0%b%b %h %h %h %h %h %b %0d",
                     n, tmo, gv, ge, buttons, rx, ry, lx, ly, analog, bcyc,
                     v, !v, exp_buttons, exp_rx, exp_ry, exp_lx, exp_ly, exp_analog, T_TICKS * CD);
         end
      end
   endtask

   task automatic test_back_to_back();
      int rises = 0, pulses = 0;
      logic prev;
      bit v;
      random_resp(1'b1);
      model_frame(v);
      prev = busy;
      start = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         @(negedge CLK_40M);
         start = (i == 100) || (i == 600);
         if (busy && !prev) rises++;
         if (frame_valid) pulses++;
         prev = busy;
      end
      start = 1'b0;
      nvec++;
      if ({rises, pulses} !== {32'd1, 32'd1}) begin
         nmis++;
         $display("FAIL busy_start_ignored: got %0d frames %0d pulses expected 1 1", rises, pulses);
      end
      nvec++;
      if ({buttons, rx, ry, lx, ly, analog} !== {exp_buttons, exp_rx, exp_ry, exp_lx, exp_ly, exp_analog}) begin
         nmis++;
         $display("FAIL b2b_outputs: got %h %h %h %h %h %b expected %h %h %h %h %h %b",
                  buttons, rx, ry, lx, ly, analog,
                  exp_buttons, exp_rx, exp_ry, exp_lx, exp_ly, exp_analog);
      end
   endtask

   task automatic test_auto();
      int cnt;
      logic prev;
      bit v;
      random_resp(1'b1);
      model_frame(v);
      auto_en = 1'b1;
      cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK_40M);
         cnt++;
         if (busy) break;
      end
      nvec++;
      if (cnt != PP) begin
         nmis++;
         $display("FAIL auto_first_start: got %0d cycles expected %0d", cnt, PP);
      end
      for (int p = 0; p < 2; p++) begin
         cnt = 0;
         prev = 1'b1;
         for (int i = 0; i < 3000; i++) begin
            @(negedge CLK_40M);
            cnt++;
            start = (p == 0) && (cnt == 200);
            if (busy && !prev) break;
            prev = busy;
         end
         start = 1'b0;
         nvec++;
         if (cnt != PP) begin
            nmis++;
            $display("FAIL auto_period_%0d: got %0d cycles expected %0d", p, cnt, PP);
         end
      end
      auto_en = 1'b0;
      for (int i = 0; i < 3000 && busy; i++) @(negedge CLK_40M);
      cnt = 0;
      for (int i = 0; i < 2500; i++) begin
         @(negedge CLK_40M);
         if (busy) cnt++;
      end
      nvec++;
      if (cnt != 0) begin
         nmis++;
         $display("FAIL auto_off: got %0d busy cycles expected 0", cnt);
      end
      nvec++;
      if ({buttons, rx, ry, lx, ly, analog} !== {exp_buttons, exp_rx, exp_ry, exp_lx, exp_ly, exp_analog}) begin
         nmis++;
         $display("FAIL auto_outputs: got %h %h %h %h %h %b expected %h %h %h %h %h %b",
                  buttons, rx, ry, lx, ly, analog,
                  exp_buttons, exp_rx, exp_ry, exp_lx, exp_ly, exp_analog);
      end
   endtask

   task automatic test_reset_midframe();
      int bcyc, slo;
      bit gv, ge, tmo, v, reached;
      random_resp(1'b1);
      model_frame(v);
      low_pulses = 0;
      reached = 0;
      start = 1'b1;
      @(negedge CLK_40M);
      start = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (low_pulses >= 36) begin
            reached = 1;
            break;
         end
         @(negedge CLK_40M);
      end
      nvec++;
      if (!reached) begin
         nmis++;
         $display("FAIL midframe_reach: got %0d sclk pulses expected 36", low_pulses);
      end
      rst = 1'b0;
      #1;
      model_reset();
      nvec++;
      if ({scs, sclk, sdo, busy, frame_valid, frame_err, analog, buttons, rx, ry, lx, ly} !==
          {7'b1110000, 16'h0000, {4{8'h80}}}) begin
         nmis++;
         $display("FAIL midframe_reset: got %b %h %h %h %h %h expected 1110000 0000 80 80 80 80",
                  {scs, sclk, sdo, busy, frame_valid, frame_err, analog}, buttons, rx, ry, lx, ly);
      end
      @(negedge CLK_40M);
      rst = 1'b1;
      @(negedge CLK_40M);
      random_resp(1'b1);
      model_frame(v);
      do_frame(1'b1, bcyc, slo, gv, ge, tmo);
      nvec++;
      if ({tmo, gv, ge, bcyc, low_pulses, buttons, rx, ry, lx, ly, analog} !==
          {3'b010, T_TICKS * CD, NB * 8, exp_buttons, exp_rx, exp_ry, exp_lx, exp_ly, exp_analog}) begin
         nmis++;
         $display("FAIL post_reset_frame: got %b %0d %0d %h %h %h %h %h %b expected 010 %0d %0d %h %h %h %h %h %b",
                  {tmo, gv, ge}, bcyc, low_pulses, buttons, rx, ry, lx, ly, analog,
                  T_TICKS * CD, NB * 8, exp_buttons, exp_rx, exp_ry, exp_lx, exp_ly, exp_analog);
      end
   endtask

   initial begin
      logic [7:0] cb;
      nvec = 0;
      nmis = 0;
      rst = 1'b0;
      start = 1'b0;
      auto_en = 1'b0;
      low_pulses = 0;
      for (int i = 0; i < NB; i++) resp[i] = 8'hFF;
      for (int b = 0; b < NB; b++) begin
         cb = (b == 0) ? 8'h01 : (b == 1) ? 8'h42 : 8'h00;
         for (int k = 0; k < 8; k++) exp_mosi.push_back(cb[k]);
      end
      model_reset();
      repeat (3) @(negedge CLK_40M);
      test_reset();
      rst = 1'b1;
      test_idle_hold();
      test_analog_frame();
      test_digital_frame();
      test_bad_frame();
      test_random();
      test_back_to_back();
      test_auto();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
